ahb_arbiter: RTL
================

Name: ahb_arbiter

Overview:
- Shares one AHB bus between up to NUM_MASTERS ahb_master instances.
- Samples per-master HBUSREQ/HLOCK and issues a one-hot HGRANT.
- Tracks the current owner's burst from HTRANS/HBURST/HREADY/HRESP so that fixed-length bursts and locked sequences are never split.
- Drives HMASTER/HMASTER_D for the address-mux and write-data-mux select.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
DEFAULT_MASTER, 0, index granted when nobody requests
MW, $clog2(NUM_MASTERS), width of master index outputs

Ports:
HCLK  in  1  bus clock, all logic on rising edge
HRESET  in  1  asynchronous, active-high reset
HBUSREQ  in  NUM_MASTERS  per-master bus request
HLOCK  in  NUM_MASTERS  per-master locked-transfer request
HTRANS  in  2  muxed owner transfer type: IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
HBURST  in  3  muxed owner burst: SINGLE=000 INCR=001 WRAP4=010 INCR4=011 WRAP8=100 INCR8=101 WRAP16=110 INCR16=111
HREADY  in  1  bus ready
HRESP  in  2  OKAY=00 ERROR=01 RETRY=10 SPLIT=11
HGRANT  out  NUM_MASTERS  one-hot grant, registered
HMASTER  out  MW  address-phase owner index
HMASTER_D  out  MW  data-phase owner index
HMASTLOCK  out  1  current address phase is locked

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-high (HCLK, HRESET).
- Reset values:
  - HGRANT = one-hot(DEFAULT_MASTER); HMASTER = HMASTER_D = DEFAULT_MASTER; HMASTLOCK = 0.
  - state = ST_ARB; beat counter = 0; round-robin pointer = DEFAULT_MASTER.
  - Reset mid-burst aborts immediately to these values.
- Ownership pipeline, only on edges with HREADY=1:
  - HMASTER <= index(HGRANT).
  - HMASTER_D <= HMASTER.
  - HMASTLOCK <= HLOCK[index(HGRANT)].
  - With HREADY=0, all three hold.
- Grant update:
  - HGRANT is recomputed only on an edge with HREADY=1 while rearbitration is permitted.
  - Otherwise HGRANT holds.
  - A new grant reaches HMASTER one HREADY edge later (standard one-cycle handover).
- Arbitration (ahb_rr_picker):
  - Round-robin over HBUSREQ, searching from (pointer+1) mod NUM_MASTERS.
  - Winner found: HGRANT = winner, pointer = winner.
  - No request: grant DEFAULT_MASTER, pointer unchanged.
  - A sole requester keeps its grant indefinitely.
- State machine:
  - ST_ARB → rearbitration permitted on every HREADY edge.
    - HTRANS=NONSEQ and HBURST fixed-length (4/8/16 beats): load counter = beats−1, go ST_BURST, do not rearbitrate on that edge.
    - SINGLE and INCR stay in ST_ARB.
    - HLOCK[owner]=1 on the NONSEQ edge: go ST_LOCK (takes precedence over ST_BURST).
  - ST_BURST → HGRANT frozen.
    - Each HREADY edge with HTRANS=SEQ decrements the counter; BUSY and wait states do not.
    - Counter reaches 0 on that edge: rearbitrate on the same edge, return to ST_ARB.
    - HTRANS=IDLE or NONSEQ seen (early termination): counter cleared, ST_ARB, rearbitrate that edge.
  - ST_LOCK → HGRANT frozen.
    - Exit to ST_ARB on the first HREADY edge where HLOCK[owner]=0 and HTRANS ∈ {IDLE, NONSEQ}.
- Error handling:
  - HRESP ≠ OKAY with HREADY=0 (first response cycle) from ST_BURST or ST_LOCK: counter cleared, state → ST_ARB.
  - Rearbitration then occurs at the second response cycle (HREADY=1).
- Simultaneous events:
  - Final SEQ beat plus a new request: rearbitrate on that edge; the request is visible.
  - Reset dominates everything.
- Counter width: 4 bits, no wrap (loaded ≤15).

Decomposition:
- Package ahb_pkg:
  - HTRANS/HBURST/HRESP encodings.
  - State enum {ST_ARB, ST_BURST, ST_LOCK}.
  - Function burst_beats(HBURST) returning 1/0(unbounded)/4/8/16.
- Sub-module ahb_rr_picker: purely combinational round-robin one-hot picker.
  - Inputs: req vector, pointer.
  - Outputs: grant vector, winner index, any_req.

Test Plan:
- Reset, no requests:
  - HGRANT=4'b0001, HMASTER=0 held for 10 cycles.
  - Assert HRESET mid-run → same values asynchronously.
- HBUSREQ=4'b0110, HREADY=1, IDLE traffic:
  - Grant sequence 0010, 0100, 0010…
  - HMASTER follows one edge later.
- Master 2 NONSEQ INCR8 then 7 SEQ beats with two BUSY and three HREADY=0 cycles, master 1 requesting throughout:
  - HGRANT stays 0100 until the edge of the 7th SEQ beat, then 0010.
- Master 3 HLOCK=1 with INCR4 then SINGLE, master 0 requesting:
  - HGRANT stays 1000 and HMASTLOCK=1 until HLOCK drops and IDLE is sent.
- ERROR during INCR16 beat 5 (HRESP=01, HREADY=0 then 1):
  - Regrant to the next requester on the HREADY=1 edge.
  - Counter reads 0.
- Write data path: master 1 NONSEQ then master 2 NONSEQ back-to-back:
  - HMASTER_D lags HMASTER by exactly one HREADY edge, including across a 2-cycle wait state.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB arbiter shared definitions: bus encodings, arbiter state and burst length decode.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef logic [3:0] beat_cnt_t;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_LOCK  = 2'd2
  } arb_state_e;

  // Beats in a burst; 0 marks an unbounded INCR.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE:               return 5'd1;
      HBURST_INCR:                 return 5'd0;
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      default:                     return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: nearest requester after ptr wins, ptr itself last.
module ahb_rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [MW-1:0]          winner,
  output logic                   any_req
);

  logic [MW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit is kept.
  always_comb begin
    grant   = '0;
    winner  = '0;
    cand    = '0;
    any_req = |req;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = MW'((int'(ptr) + i) % NUM_MASTERS);
      if (req[cand]) winner = cand;
    end
    if (any_req) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant that never splits fixed-length bursts or locked sequences.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic [MW-1:0]          HMASTER_D,
  output logic                   HMASTLOCK
);

  localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  arb_state_e state, state_nxt;
  beat_cnt_t  beat_cnt, cnt_nxt;
  logic [MW-1:0] rr_ptr;
  logic [MW-1:0] grant_idx;
  logic          rearb;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [MW-1:0]          pick_idx;
  logic                   pick_any;

  logic       owner_lock;
  logic       is_nonseq;
  logic       is_idle;
  logic       err_first;
  logic [4:0] beats;

  ahb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .MW         (MW)
  ) u_picker (
    .req    (HBUSREQ),
    .ptr    (rr_ptr),
    .grant  (pick_grant),
    .winner (pick_idx),
    .any_req(pick_any)
  );

  // HTRANS/HBURST/HLOCK are judged against the address-phase owner.
  assign owner_lock = HLOCK[HMASTER];
  assign is_nonseq  = (HTRANS == HTRANS_NONSEQ);
  assign is_idle    = (HTRANS == HTRANS_IDLE);
  assign err_first  = (HRESP != HRESP_OKAY) && !HREADY;
  assign beats      = burst_beats(HBURST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    rearb     = 1'b0;
    case (state)
      ST_ARB: begin
        if (HREADY) begin
          if (is_nonseq && owner_lock) begin
            state_nxt = ST_LOCK;
          end else if (is_nonseq && beats >= 5'd4) begin
            state_nxt = ST_BURST;
            cnt_nxt   = beat_cnt_t'(beats - 5'd1);
          end else begin
            rearb = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if (err_first) begin
          state_nxt = ST_ARB;
          cnt_nxt   = '0;
        end else if (HREADY) begin
          if (is_idle || is_nonseq) begin
            state_nxt = ST_ARB;
            cnt_nxt   = '0;
            rearb     = 1'b1;
          end else if (HTRANS == HTRANS_SEQ) begin
            if (beat_cnt <= beat_cnt_t'(1)) begin
              state_nxt = ST_ARB;
              cnt_nxt   = '0;
              rearb     = 1'b1;
            end else begin
              cnt_nxt = beat_cnt - beat_cnt_t'(1);
            end
          end
        end
      end
      ST_LOCK: begin
        if (err_first) begin
          state_nxt = ST_ARB;
          cnt_nxt   = '0;
        end else if (HREADY && !owner_lock && (is_idle || is_nonseq)) begin
          state_nxt = ST_ARB;
          rearb     = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_ARB;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_ARB;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // Grant and the address/data ownership pipeline advance only on HREADY edges.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HGRANT    <= DEF_GRANT;
      grant_idx <= DEF_IDX;
      rr_ptr    <= DEF_IDX;
      HMASTER   <= DEF_IDX;
      HMASTER_D <= DEF_IDX;
      HMASTLOCK <= 1'b0;
    end else begin
      if (HREADY) begin
        HMASTER   <= grant_idx;
        HMASTER_D <= HMASTER;
        HMASTLOCK <= HLOCK[grant_idx];
      end
      if (rearb) begin
        if (pick_any) begin
          HGRANT    <= pick_grant;
          grant_idx <= pick_idx;
          rr_ptr    <= pick_idx;
        end else begin
          HGRANT    <= DEF_GRANT;
          grant_idx <= DEF_IDX;
        end
      end
    end
  end

endmodule
